// File: rtl/zap_decode_mem_fsm.sv
// Decode-frontend stage: expands LDM/STM block transfers into single-register
// LDR/STR micro-ops plus an optional base write-back ADD/SUB. Everything else
// passes straight through. Fetch is stalled and interrupts masked mid-sequence.
module zap_decode_mem_fsm (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_fiq,
  input  logic        i_irq,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_stall_from_issue,
  input  logic        i_stall_from_bl,
  input  logic [34:0] i_instruction,
  input  logic        i_instruction_valid,
  output logic [34:0] o_instruction,
  output logic        o_instruction_valid,
  output logic        o_stall_from_decode,
  output logic        o_fiq,
  output logic        o_irq
);

  typedef enum logic [1:0] {IDLE, XFER, WB} state_t;

  state_t      state, adv_state;
  logic [15:0] mask, adv_mask;
  logic [4:0]  k, adv_k;
  logic        wb_pending, adv_wb;

  // Instruction fields; fetch keeps the block instruction stable while stalled.
  logic [3:0]  cond, rn;
  logic        p_bit, u_bit, w_bit, l_bit;
  logic [15:0] list;
  assign cond  = i_instruction[31:28];
  assign p_bit = i_instruction[24];
  assign u_bit = i_instruction[23];
  assign w_bit = i_instruction[21];
  assign l_bit = i_instruction[20];
  assign rn    = i_instruction[19:16];
  assign list  = i_instruction[15:0];

  // S bit is treated as 0 and the top sideband bits are not decoded here.
  logic unused_bits;
  assign unused_bits = ^{i_instruction[34:32], i_instruction[22]};

  logic is_block, start, wb_req;
  assign is_block = i_instruction_valid && (i_instruction[27:25] == 3'b100);
  assign start    = is_block && (list != 16'h0) && (state == IDLE);
  // Loading the base register makes its write-back meaningless, so skip it.
  assign wb_req   = w_bit && !(l_bit && list[rn]);

  // Register count of the block transfer.
  logic [4:0] n;
  always_comb begin
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + 5'(list[i]);
  end

  // Offset of the current micro-op: start offset for the mode plus 4 per step.
  logic signed [9:0] n4, start_off, off;
  logic [9:0]        abs_off;
  logic [4:0]        k_cur;
  assign n4    = $signed({3'b000, n, 2'b00});
  assign k_cur = (state == IDLE) ? 5'd0 : k;
  always_comb begin
    start_off = 10'sd0;
    case ({p_bit, u_bit})
      2'b01: start_off = 10'sd0;        // IA
      2'b11: start_off = 10'sd4;        // IB
      2'b00: start_off = 10'sd4 - n4;   // DA
      2'b10: start_off = -n4;           // DB
      default: start_off = 10'sd0;
    endcase
    off     = start_off + $signed({3'b000, k_cur, 2'b00});
    abs_off = off[9] ? 10'(-off) : 10'(off);
  end

  // Lowest pending register: from the list on the first op, else from the mask.
  logic [15:0] src;
  logic [3:0]  rd;
  assign src = (state == IDLE) ? list : mask;
  always_comb begin
    rd = 4'd0;
    for (int i = 15; i >= 0; i--) if (src[i]) rd = 4'(i);
  end

  logic [34:0] xfer_op, wb_op;
  assign xfer_op = {3'b000, cond, 3'b010, 1'b1, ~off[9], 1'b0, 1'b0, l_bit,
                    rn, rd, 2'b00, abs_off};
  assign wb_op   = {3'b000, cond, 3'b001, (u_bit ? 4'b0100 : 4'b0010), 1'b0,
                    rn, rn, 4'b0000, 1'b0, n, 2'b00};

  // Next state as if the pipeline advances this cycle.
  always_comb begin
    adv_state = IDLE;
    adv_mask  = 16'h0;
    adv_k     = 5'd0;
    adv_wb    = 1'b0;
    case (state)
      IDLE: if (start) begin
        adv_mask  = list & (list - 16'd1);
        adv_k     = 5'd1;
        adv_wb    = wb_req;
        adv_state = (adv_mask != 16'h0) ? XFER : (wb_req ? WB : IDLE);
      end
      XFER: begin
        adv_mask  = mask & (mask - 16'd1);
        adv_k     = k + 5'd1;
        adv_wb    = wb_pending;
        adv_state = (adv_mask != 16'h0) ? XFER : (wb_pending ? WB : IDLE);
      end
      default: adv_state = IDLE;
    endcase
  end

  // Priority decode of flush vs. hold for this cycle.
  logic flush, hold;
  assign flush = i_reset || i_clear_from_writeback ||
                 (!i_data_stall && i_clear_from_alu);
  assign hold  = !flush && (i_data_stall || i_stall_from_issue || i_stall_from_bl);

  // Sequence registers: flush abandons, hold re-presents, otherwise advance.
  always_ff @(posedge i_clk) begin
    if (flush) begin
      state      <= IDLE;
      mask       <= 16'h0;
      k          <= 5'd0;
      wb_pending <= 1'b0;
    end else if (!hold) begin
      state      <= adv_state;
      mask       <= adv_mask;
      k          <= adv_k;
      wb_pending <= adv_wb;
    end
  end

  // Micro-op select, fetch stall and interrupt masking.
  always_comb begin
    o_instruction = i_instruction;
    case (state)
      IDLE:    if (start) o_instruction = xfer_op;
      XFER:    o_instruction = xfer_op;
      WB:      o_instruction = wb_op;
      default: o_instruction = i_instruction;
    endcase
    o_instruction_valid = i_instruction_valid;
    o_stall_from_decode = !flush && ((adv_state != IDLE) ||
                                     (hold && (start || state != IDLE)));
    o_irq = i_irq && !(start || state != IDLE);
    o_fiq = i_fiq && !(start || state != IDLE);
  end

endmodule

// File: doc/zap_decode_mem_fsm.md
# zap_decode_mem_fsm

Decode-frontend stage that sits between fetch and the BL FSM and expands ARM block transfers (LDM/STM) into a sequence of single-register LDR/STR micro-ops plus an optional base write-back micro-op. All other instructions pass through unchanged. While a sequence is in flight, the block stalls fetch and masks interrupts.

## Interface
- No parameters.
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_fiq, i_irq  in  1 each  interrupt levels.
- i_clear_from_writeback  in  1  flush; highest priority.
- i_data_stall  in  1  memory stall.
- i_clear_from_alu  in  1  flush.
- i_stall_from_issue  in  1  issue stall; lowest priority.
- i_stall_from_bl  in  1  stall from the downstream BL FSM.
- i_instruction  in  35  instruction from fetch.
- i_instruction_valid  in  1  qualifies i_instruction.
- o_instruction  out  35  micro-op to the BL FSM.
- o_instruction_valid  out  1  micro-op valid.
- o_stall_from_decode  out  1  holds fetch and PC.
- o_fiq, o_irq  out  1 each  forwarded or masked interrupts.

## Operation
- Block transfer detect: valid, [27:25]=100. Fields: cond[31:28], P[24], U[23], S[22] (ignored, treated as 0), W[21], L[20], Rn[19:16], list[15:0]. N = popcount(list).
- Empty list or non-block instruction: pass through unchanged, no stall.
- Start offset: IA 0; IB +4; DA 4-4N; DB -4N. Micro-op k (k=0..N-1, registers in ascending index) uses offset off_k = start+4k.
- Transfer micro-op: {3'b000, cond, 3'b010, P=1, U=(off_k>=0), B=0, W=0, L, Rn, Rd, imm12=|off_k|}.
- Write-back micro-op (when W=1, unless L=1 and Rn is in list): {3'b000, cond, 3'b001, opcode ADD 0100 if U else SUB 0010, S=0, Rn, Rn, rot=0, imm8=4N}.
- States: IDLE, XFER, WB. Registers: remaining mask (16b), k (5b), latched wb_pending.
- IDLE, block detected: emit micro-op 0 combinationally. Mask = list minus lowest bit. Next state: XFER if N>1, WB if N=1 and wb_pending, else IDLE.
- XFER: emit the lowest set bit of the mask, then clear it and increment k. On the last register, next state is WB if wb_pending, else IDLE.
- WB: emit the write-back micro-op; next state IDLE.
- o_stall_from_decode=1 whenever the next state is not IDLE. It drops on the cycle the final micro-op is emitted.
- o_irq/o_fiq = 0 when a sequence starts or state≠IDLE; otherwise they equal the inputs.
- o_instruction_valid = i_instruction_valid. Fetch holds the block instruction stable while stalled.

## Timing
- Outputs are combinational from state and input. Zero latency.
- Sequence length is N+wb_pending cycles. Fetch is stalled for N+wb_pending-1 cycles.
- Sequential update priority: i_reset > i_clear_from_writeback > i_data_stall (hold) > i_clear_from_alu > i_stall_from_issue or i_stall_from_bl (hold) > advance.
- Reset or a clear returns state to IDLE, clears the mask and k to 0, and sets wb_pending to 0. A clear in mid-sequence abandons it with no write-back.
- Reset output values: o_stall_from_decode=0. Other outputs track their inputs combinationally.
- On a hold, the same micro-op is re-presented next cycle. o_stall_from_decode stays asserted.

## Test plan
- LDMIA R0!,{R1-R3} (E8B0000E) -> E5901000, E5902004, E5903008, E280000C. Stall is 1,1,1,0 and irq is masked for all 4 cycles.
- STMDB R13!,{R4,LR} (E92D4010) -> E50D4008, E50DE004, E24DD008.
- LDMIA R0!,{R0,R1} (E8B00003) -> E5900000, E5901004 only; no write-back, stall 1,0.
- E8B0000E with i_clear_from_alu asserted after the 2nd micro-op -> state returns to IDLE, next output is the raw input, stall 0.
- E8B0000E with i_stall_from_issue high for 3 cycles at the 2nd micro-op -> E5902004 is held for 3 cycles, then the sequence resumes.
- ADD E2811001 with irq=1 -> passed unchanged, stall 0, o_irq=1.
